// File: rtl/exc_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exc_seq_ctrl_pkg
// Description : Shared constants for the exception commit sequencer: FSM
//               state encodings, CP0 ExcCode values, the ERET type code and
//               the exception vector.
// Revision    : 1.0 - initial release
// ============================================================================
package exc_seq_ctrl_pkg;

  // Sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    EXC_IDLE     = 2'd0,
    EXC_DRAIN    = 2'd1,
    EXC_COMMIT   = 2'd2,
    EXC_REDIRECT = 2'd3
  } exc_state_e;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT     = 5'h00;
  localparam logic [4:0] EXC_ADEL    = 5'h04;
  localparam logic [4:0] EXC_ADES    = 5'h05;
  localparam logic [4:0] EXC_SYS     = 5'h08;
  localparam logic [4:0] EXC_BP      = 5'h09;
  localparam logic [4:0] EXC_RI      = 5'h0a;
  localparam logic [4:0] EXC_OV      = 5'h0c;
  localparam logic [4:0] EXC_UNKNOWN = 5'h1f;

  // Type code used by exceptdec to signal ERET
  localparam logic [31:0] EXC_TYPE_ERET = 32'h0000_000e;

  // Exception vector
  localparam logic [31:0] EXCEPT_PC = 32'hbfc0_0380;

  // EPC points back at the branch when the faulting instruction is in its delay slot
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exc_seq_ctrl_exccode_map.sv
`default_nettype none
// ============================================================================
// Module      : exccode_map
// Description : Decodes the exceptdec type code into Cause.ExcCode, a
//               BadVAddr-write qualifier and an ERET indicator.
// Revision    : 1.0 - initial release
// ============================================================================
module exccode_map
  import exc_seq_ctrl_pkg::*;
(
  input  logic [31:0] except_type,
  output logic [4:0]  exccode,
  output logic        is_badaddr,
  output logic        is_eret
);

  // Pure table lookup; unrecognised codes report 0x1f and never touch BadVAddr
  always_comb begin
    exccode    = EXC_UNKNOWN;
    is_badaddr = 1'b0;
    is_eret    = 1'b0;
    case (except_type)
      32'h0000_0000: exccode = EXC_INT;
      32'h0000_0004: begin
        exccode    = EXC_ADEL;
        is_badaddr = 1'b1;
      end
      32'h0000_0005: begin
        exccode    = EXC_ADES;
        is_badaddr = 1'b1;
      end
      32'h0000_0008: exccode = EXC_SYS;
      32'h0000_0009: exccode = EXC_BP;
      32'h0000_000a: exccode = EXC_RI;
      32'h0000_000c: exccode = EXC_OV;
      EXC_TYPE_ERET: is_eret = 1'b1;
      default:       exccode = EXC_UNKNOWN;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/exc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_seq_ctrl
// Description : Multi-cycle exception / ERET commit sequencer. Latches one
//               request, stalls the pipeline, waits for bus and divider to
//               drain (bounded by DRAIN_MAX), issues a one-cycle CP0 update
//               and then a one-cycle flush plus PC redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_seq_ctrl
  import exc_seq_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_except,
  input  logic [31:0] except_type,
  input  logic [31:0] except_pc,
  input  logic [31:0] pcM,
  input  logic        is_in_delayslotM,
  input  logic [31:0] badvaddrM,
  input  logic        mem_busy,
  input  logic        div_busy,
  output logic        stall_req,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        cp0_exc_we,
  output logic [31:0] cp0_epc_wdata,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_bd,
  output logic        cp0_badvaddr_we,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_exl_clr,
  output logic        drain_timeout
);

  localparam logic [7:0] DRAIN_LIMIT = 8'(DRAIN_MAX);

  exc_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic [31:0] type_q, type_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic [31:0] bad_q, bad_d;

  logic [4:0]  map_exccode;
  logic        map_is_badaddr;
  logic        map_is_eret;

  exccode_map u_exccode_map (
    .except_type (type_q),
    .exccode     (map_exccode),
    .is_badaddr  (map_is_badaddr),
    .is_eret     (map_is_eret)
  );

  // State, drain counter, sticky timeout flag and request latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EXC_IDLE;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
      type_q    <= 32'd0;
      tgt_q     <= 32'd0;
      pc_q      <= 32'd0;
      bd_q      <= 1'b0;
      bad_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      type_q    <= type_d;
      tgt_q     <= tgt_d;
      pc_q      <= pc_d;
      bd_q      <= bd_d;
      bad_q     <= bad_d;
    end
  end

  // Next-state logic; requests are only accepted in IDLE, never queued
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    type_d    = type_q;
    tgt_d     = tgt_q;
    pc_d      = pc_q;
    bd_d      = bd_q;
    bad_d     = bad_q;
    case (state_q)
      EXC_IDLE: begin
        if (is_except) begin
          type_d  = except_type;
          tgt_d   = except_pc;
          pc_d    = pcM;
          bd_d    = is_in_delayslotM;
          bad_d   = badvaddrM;
          cnt_d   = 8'd0;
          state_d = EXC_DRAIN;
        end
      end
      EXC_DRAIN: begin
        if (!mem_busy && !div_busy) begin
          state_d = EXC_COMMIT;
        end else if (cnt_q == DRAIN_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = EXC_COMMIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      EXC_COMMIT:   state_d = EXC_REDIRECT;
      EXC_REDIRECT: state_d = EXC_IDLE;
      default:      state_d = EXC_IDLE;
    endcase
  end

  // Moore output decode from state and latched request
  always_comb begin
    flush           = 1'b0;
    pc_redirect     = 1'b0;
    cp0_exc_we      = 1'b0;
    cp0_badvaddr_we = 1'b0;
    cp0_exl_clr     = 1'b0;
    case (state_q)
      EXC_COMMIT: begin
        cp0_exc_we      = !map_is_eret;
        cp0_badvaddr_we = map_is_badaddr;
        cp0_exl_clr     = map_is_eret;
      end
      EXC_REDIRECT: begin
        flush       = 1'b1;
        pc_redirect = 1'b1;
      end
      default: ;
    endcase
  end

  // Stall covers the request cycle itself so nothing advances past M
  assign stall_req     = (state_q != EXC_IDLE) | is_except;

  assign redirect_pc   = tgt_q;
  assign cp0_epc_wdata = epc_of(pc_q, bd_q);
  assign cp0_exccode   = map_exccode;
  assign cp0_bd        = bd_q;
  assign cp0_badvaddr  = bad_q;
  assign drain_timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_exc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exc_seq_ctrl
// Description : Scoreboard bench for exc_seq_ctrl. Directed requests push
//               expected COMMIT / REDIRECT events; a monitor pops and
//               compares whenever the DUT shows a CP0 write or redirect.
//               A second instance with DRAIN_MAX=3 covers the timeout path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_except = 1'b0;
  logic [31:0] except_type = 32'd0;
  logic [31:0] except_pc = 32'd0;
  logic [31:0] pcM = 32'd0;
  logic        is_in_delayslotM = 1'b0;
  logic [31:0] badvaddrM = 32'd0;
  logic        mem_busy = 1'b0;
  logic        div_busy = 1'b0;
  logic        is_except2 = 1'b0;
  logic        mem_busy2 = 1'b0;

  logic        stall_req, flush, pc_redirect, cp0_exc_we, cp0_bd;
  logic        cp0_badvaddr_we, cp0_exl_clr, drain_timeout;
  logic [31:0] redirect_pc, cp0_epc_wdata, cp0_badvaddr;
  logic [4:0]  cp0_exccode;

  logic        stall_req2, flush2, pc_redirect2, cp0_exc_we2, cp0_bd2;
  logic        cp0_badvaddr_we2, cp0_exl_clr2, drain_timeout2;
  logic [31:0] redirect_pc2, cp0_epc_wdata2, cp0_badvaddr2;
  logic [4:0]  cp0_exccode2;

  localparam logic [31:0] VEC = 32'hbfc00380;

  exc_seq_ctrl u_dut (
    .clk(clk), .rst(rst), .is_except(is_except), .except_type(except_type),
    .except_pc(except_pc), .pcM(pcM), .is_in_delayslotM(is_in_delayslotM),
    .badvaddrM(badvaddrM), .mem_busy(mem_busy), .div_busy(div_busy),
    .stall_req(stall_req), .flush(flush), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .cp0_exc_we(cp0_exc_we), .cp0_epc_wdata(cp0_epc_wdata),
    .cp0_exccode(cp0_exccode), .cp0_bd(cp0_bd), .cp0_badvaddr_we(cp0_badvaddr_we),
    .cp0_badvaddr(cp0_badvaddr), .cp0_exl_clr(cp0_exl_clr), .drain_timeout(drain_timeout)
  );

  exc_seq_ctrl #(.DRAIN_MAX(3)) u_dut_to (
    .clk(clk), .rst(rst), .is_except(is_except2), .except_type(except_type),
    .except_pc(except_pc), .pcM(pcM), .is_in_delayslotM(is_in_delayslotM),
    .badvaddrM(badvaddrM), .mem_busy(mem_busy2), .div_busy(1'b0),
    .stall_req(stall_req2), .flush(flush2), .pc_redirect(pc_redirect2),
    .redirect_pc(redirect_pc2), .cp0_exc_we(cp0_exc_we2), .cp0_epc_wdata(cp0_epc_wdata2),
    .cp0_exccode(cp0_exccode2), .cp0_bd(cp0_bd2), .cp0_badvaddr_we(cp0_badvaddr_we2),
    .cp0_badvaddr(cp0_badvaddr2), .cp0_exl_clr(cp0_exl_clr2), .drain_timeout(drain_timeout2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    bit          is_redirect;
    bit          exc_we;
    bit          exl;
    bit          bvwe;
    logic [4:0]  code;
    logic [31:0] epc;
    bit          bd;
    logic [31:0] bad;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: any CP0 write or redirect must match the oldest expected event
  always @(negedge clk) begin
    if (cp0_exc_we || cp0_exl_clr || cp0_badvaddr_we || flush || pc_redirect) begin
      chk("event_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("event_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("stall_during_seq", 32'(stall_req), 32'd1);
        if (mon_e.is_redirect) begin
          chk("rd_flush", 32'(flush), 32'd1);
          chk("rd_pc_redirect", 32'(pc_redirect), 32'd1);
          chk("rd_redirect_pc", redirect_pc, mon_e.rpc);
          chk("rd_no_exc_we", 32'(cp0_exc_we), 32'd0);
        end else begin
          chk("cm_exc_we", 32'(cp0_exc_we), 32'(mon_e.exc_we));
          chk("cm_exl_clr", 32'(cp0_exl_clr), 32'(mon_e.exl));
          chk("cm_badvaddr_we", 32'(cp0_badvaddr_we), 32'(mon_e.bvwe));
          chk("cm_no_flush", 32'(flush), 32'd0);
          if (mon_e.exc_we) begin
            chk("cm_exccode", 32'(cp0_exccode), 32'(mon_e.code));
            chk("cm_epc", cp0_epc_wdata, mon_e.epc);
            chk("cm_bd", 32'(cp0_bd), 32'(mon_e.bd));
          end
          if (mon_e.bvwe) chk("cm_badvaddr", cp0_badvaddr, mon_e.bad);
        end
      end
    end
  end

  // One request; nbusy DRAIN cycles of div_busy; optional type-0xc noise in DRAIN/COMMIT
  task automatic run_req(input logic [31:0] typ, input logic [31:0] tgt, input logic [31:0] pc,
                         input logic bd, input logic [31:0] bad, input int nbusy, input bit spurious,
                         input bit e_eret, input bit e_bvwe, input logic [4:0] e_code,
                         input logic [31:0] e_epc);
    exp_t e;
    int   k;
    @(posedge clk); #1;
    chk("idle_no_stall", 32'(stall_req), 32'd0);
    k = cyc;
    is_except = 1'b1; except_type = typ; except_pc = tgt; pcM = pc;
    is_in_delayslotM = bd; badvaddrM = bad; div_busy = (nbusy > 0);
    e = '{cyc: k + 2 + nbusy, is_redirect: 1'b0, exc_we: !e_eret, exl: e_eret, bvwe: e_bvwe,
          code: e_code, epc: e_epc, bd: bd, bad: bad, rpc: tgt};
    sb_q.push_back(e);
    e.cyc = k + 3 + nbusy;
    e.is_redirect = 1'b1;
    sb_q.push_back(e);
    #1;
    chk("stall_cycle0", 32'(stall_req), 32'd1);
    for (int c = 1; c <= nbusy + 3; c++) begin
      @(posedge clk); #1;
      is_except = spurious && (c <= nbusy + 2);
      if (spurious) begin
        except_type = 32'hc; except_pc = 32'h11111110; pcM = 32'h22222220;
        is_in_delayslotM = ~bd; badvaddrM = 32'h33333330;
      end
      div_busy = (c <= nbusy);
    end
  endtask

  task automatic chk_main_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall_req), 32'd0);
    chk({tag, "_flush"}, 32'({flush, pc_redirect, cp0_exc_we, cp0_badvaddr_we, cp0_exl_clr}), 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, "_epc"}, cp0_epc_wdata, 32'd0);
    chk({tag, "_exccode_bd"}, 32'({cp0_exccode, cp0_bd}), 32'd0);
    chk({tag, "_badvaddr"}, cp0_badvaddr, 32'd0);
    chk({tag, "_timeout"}, 32'(drain_timeout), 32'd0);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk_main_zero("reset");
    rst = 1'b0;

    // Syscall, idle bus
    run_req(32'h8, VEC, 32'hbfc00100, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 5'd8, 32'hbfc00100);
    // Load AdEL in a delay slot (issued back-to-back)
    run_req(32'h4, VEC, 32'h80000010, 1'b1, 32'h80001001, 0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h8000000c);
    // ERET
    run_req(32'he, 32'h80000040, 32'h80000100, 1'b0, 32'h0, 0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    // Unknown type code, delay slot at PC 0 wraps EPC
    run_req(32'h3, VEC, 32'h00000000, 1'b1, 32'hdeadbeef, 0, 1'b0, 1'b0, 1'b0, 5'h1f, 32'hfffffffc);
    // Divider busy for 5 DRAIN cycles
    run_req(32'ha, VEC, 32'h00400020, 1'b0, 32'h0, 5, 1'b0, 1'b0, 1'b0, 5'd10, 32'h00400020);
    chk("no_timeout_main", 32'(drain_timeout), 32'd0);
    // AdES with a competing overflow request during DRAIN and COMMIT
    run_req(32'h5, VEC, 32'h00400100, 1'b0, 32'h00001235, 0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h00400100);

    // Timeout instance: mem_busy held high, DRAIN_MAX=3
    @(posedge clk); #1;
    k = cyc;
    is_except2 = 1'b1; mem_busy2 = 1'b1; except_type = 32'h8; except_pc = VEC;
    pcM = 32'h00400200; is_in_delayslotM = 1'b0; badvaddrM = 32'h0;
    @(posedge clk); #1;
    is_except2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("to_cycle", 32'(cyc - k), 32'd4);
    chk("to_no_commit_yet", 32'(cp0_exc_we2), 32'd0);
    chk("to_flag_not_yet", 32'(drain_timeout2), 32'd0);
    @(posedge clk); #1;
    chk("to_commit_we", 32'(cp0_exc_we2), 32'd1);
    chk("to_exccode", 32'(cp0_exccode2), 32'd8);
    chk("to_flag_set", 32'(drain_timeout2), 32'd1);
    @(posedge clk); #1;
    chk("to_redirect", 32'({flush2, pc_redirect2}), 32'd3);
    chk("to_redirect_pc", redirect_pc2, VEC);
    mem_busy2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("to_flag_sticky", 32'(drain_timeout2), 32'd1);
    chk("to_idle", 32'(stall_req2), 32'd0);

    // Reset mid-DRAIN: no CP0 write or redirect may ever appear
    @(posedge clk); #1;
    is_except = 1'b1; mem_busy = 1'b1; except_type = 32'h8; except_pc = VEC;
    pcM = 32'h00400300; badvaddrM = 32'h0;
    @(posedge clk); #1;
    is_except = 1'b0;
    @(posedge clk); #1;
    chk("mid_drain_stall", 32'(stall_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_main_zero("rst_mid");
    chk("rst_clears_timeout", 32'(drain_timeout2), 32'd0);
    @(posedge clk); #1;
    mem_busy = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_stays_idle", 32'(stall_req), 32'd0);

    chk("sb_pending", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
